// File: rtl/mem_arb.sv
// Two-port (instruction fetch / data load-store) arbiter in front of a single-port
// unified word memory, with configurable wait states and error responses.
module mem_arb #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_last_d;
  logic              r_chan_d, r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_i_ready, r_d_ready, r_i_err, r_d_err;
  logic [31:0]       r_i_rdata, r_d_rdata;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic             w_i_req, w_d_req, w_grant, w_grant_d, w_access, w_err;
  logic [IDX_W-1:0] w_idx;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == CNT_LAST) w_next = S_ACCESS;
      S_ACCESS: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // A port whose ready is high this cycle still holds req from the finished
  // transfer, so it is masked out of arbitration for that one cycle.
  always_comb begin
    w_i_req   = i_req & ~r_i_ready;
    w_d_req   = d_req & ~r_d_ready;
    w_grant   = (r_state == S_IDLE) & (w_i_req | w_d_req);
    w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
    w_access  = (r_state == S_ACCESS);
    w_err     = (|r_addr[1:0]) | (|r_addr[ADDR_W-1:IDX_W+2]);
    w_idx     = r_addr[IDX_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_last_d  <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ready <= w_access & ~r_chan_d;
      r_d_ready <= w_access &  r_chan_d;
      r_i_err   <= w_access & ~r_chan_d & w_err;
      r_d_err   <= w_access &  r_chan_d & w_err;
      r_i_rdata <= (w_access & ~r_chan_d & ~w_err) ? r_mem[w_idx] : '0;
      r_d_rdata <= (w_access & r_chan_d & ~r_we & ~w_err) ? r_mem[w_idx] : '0;
      if (w_grant) begin
        r_cnt    <= '0;
        r_last_d <= w_grant_d;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Transaction latch; only meaningful after a grant, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_chan_d <= w_grant_d;
      r_we     <= w_grant_d & d_we;
      r_be     <= d_be;
      r_addr   <= w_grant_d ? d_addr : i_addr;
      r_wdata  <= d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_access && r_chan_d && r_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (r_be[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

  assign i_ready = r_i_ready;
  assign i_rdata = r_i_rdata;
  assign i_err   = r_i_err;
  assign d_ready = r_d_ready;
  assign d_rdata = r_d_rdata;
  assign d_err   = r_d_err;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: drivers queue requests, a negedge monitor scores
// each response against a word-array model of the memory.
module tb_mem_arb;

  logic        clk = 1'b0, reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_ready, i_err, d_ready, d_err;
  logic [31:0] i_rdata, d_rdata;

  logic        i_req0 = 1'b0, i_req15 = 1'b0;
  logic        i_ready0, i_err0, d_ready0, d_err0, i_ready15, i_err15, d_ready15, d_err15;
  logic [31:0] i_rdata0, d_rdata0, i_rdata15, d_rdata15;

  always #5 clk = ~clk;

  mem_arb #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err));

  mem_arb #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset),
    .i_req(i_req0), .i_addr(32'h0), .i_ready(i_ready0), .i_rdata(i_rdata0), .i_err(i_err0),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ready(d_ready0), .d_rdata(d_rdata0), .d_err(d_err0));

  mem_arb #(.ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .reset(reset),
    .i_req(i_req15), .i_addr(32'h0), .i_ready(i_ready15), .i_rdata(i_rdata15), .i_err(i_err15),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_ready(d_ready15), .d_rdata(d_rdata15), .d_err(d_err15));

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        dq[$], iq[$];
  bit          order_q[$];   // 1 = data response, 0 = instruction response
  logic [31:0] mdl [256];
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: bad address -> err, no write, zero data; else word array access.
  task automatic score(input req_t r, input logic [31:0] rdata, input logic err, input string port);
    logic        e;
    logic [31:0] exp;
    e   = (r.addr[1:0] != 2'b00) || (r.addr >= 32'd1024);
    exp = '0;
    if (!e && !r.we) exp = mdl[r.addr[9:2]];
    if (!e && r.we)
      for (int b = 0; b < 4; b++)
        if (r.be[b]) mdl[r.addr[9:2]][8*b +: 8] = r.wdata[8*b +: 8];
    chk({port, " err"}, {31'b0, err}, {31'b0, e});
    chk({port, " rdata"}, rdata, exp);
  endtask

  initial begin : monitor
    bit i_busy, d_busy;
    i_busy = 0; d_busy = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        i_busy = 0; d_busy = 0;
      end else begin
        if (d_ready) begin
          if (dq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL d unexpected ready: got ready=1 want no response");
          end else score(dq.pop_front(), d_rdata, d_err, "d");
          order_q.push_back(1'b1);
          d_busy = 0;
        end else if (d_req) d_busy = 1;
        else if (d_busy) begin
          n_bad++; d_busy = 0;
          $display("FAIL d protocol: got req drop before ready want req held");
        end
        if (i_ready) begin
          if (iq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL i unexpected ready: got ready=1 want no response");
          end else score(iq.pop_front(), i_rdata, i_err, "i");
          order_q.push_back(1'b0);
          i_busy = 0;
        end else if (i_req) i_busy = 1;
        else if (i_busy) begin
          n_bad++; i_busy = 0;
          $display("FAIL i protocol: got req drop before ready want req held");
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the ready cycle with req dropped.
  task automatic d_xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                        output logic er);
    dq.push_back('{we, be, addr, wdata});
    d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    lat = 0; rd = '0; er = 1'b0;
    forever begin
      @(negedge clk);
      if (d_ready) begin rd = d_rdata; er = d_err; break; end
      lat++;
      if (lat > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL d timeout: got no ready want ready within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic i_fetch(input logic [31:0] addr, output int lat, output logic [31:0] rd,
                         output logic er);
    iq.push_back('{1'b0, 4'h0, addr, 32'h0});
    i_addr = addr; i_req = 1'b1;
    lat = 0; rd = '0; er = 1'b0;
    forever begin
      @(negedge clk);
      if (i_ready) begin rd = i_rdata; er = i_err; break; end
      lat++;
      if (lat > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL i timeout: got no ready want ready within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned s;
    logic [31:0] a;
    s = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 255)) * 4;
    if (s == 0)      a[1:0] = 2'($urandom_range(1, 3));
    else if (s == 1) a = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
    return a;
  endfunction

  initial begin : stim
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          l0, l15;
    logic        e0, e15;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {30'b0, d_ready, i_ready}, 32'h0);
    chk("reset err", {30'b0, d_err, i_err}, 32'h0);
    chk("reset d_rdata", d_rdata, 32'h0);
    chk("reset i_rdata", i_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int w = 0; w < 256; w++) d_xact(1'b1, 4'hF, 32'(w) * 4, $urandom, lat, rd, er);

    d_xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("store latency", 32'(lat), 32'd3);
    d_xact(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er);
    chk("load latency", 32'(lat), 32'd3);
    chk("load 0x10", rd, 32'hDEADBEEF);

    d_xact(1'b1, 4'hF, 32'h20, 32'h11223344, lat, rd, er);
    d_xact(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, lat, rd, er);
    d_xact(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er);
    chk("byte enable merge", rd, 32'h11BB33DD);
    d_xact(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, lat, rd, er);
    d_xact(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, er);
    chk("be=0 no-op", rd, 32'h11BB33DD);

    d_xact(1'b0, 4'h0, 32'h13, 32'h0, lat, rd, er);
    chk("misaligned err", {31'b0, er}, 32'h1);
    chk("misaligned latency", 32'(lat), 32'd3);
    d_xact(1'b1, 4'hF, 32'h400, 32'hFFFFFFFF, lat, rd, er);
    chk("range err", {31'b0, er}, 32'h1);
    d_xact(1'b0, 4'h0, 32'h0, 32'h0, lat, rd, er);

    // Latency of the 0- and 15-wait-state builds, both started the same cycle.
    i_req0 = 1'b1; i_req15 = 1'b1;
    l0 = -1; l15 = -1; e0 = 1'b0; e15 = 1'b0;
    for (int c = 0; c < 40 && l15 < 0; c++) begin
      @(negedge clk);
      if (i_ready0 && l0 < 0) begin l0 = c; e0 = i_err0; end
      if (i_ready15 && l15 < 0) begin l15 = c; e15 = i_err15; end
    end
    @(posedge clk); #1;
    i_req0 = 1'b0; i_req15 = 1'b0;
    chk("W0 fetch latency", 32'(l0), 32'd2);
    chk("W15 fetch latency", 32'(l15), 32'd17);
    chk("W0/W15 err", {30'b0, e0, e15}, 32'h0);
    repeat (20) @(posedge clk);
    #1;

    fork
      begin : dthr
        int l; logic [31:0] r; logic e;
        for (int k = 0; k < 60; k++) begin
          d_xact(1'($urandom_range(0, 1)), 4'($urandom), rnd_addr(), $urandom, l, r, e);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin : ithr
        int l; logic [31:0] r; logic e;
        for (int k = 0; k < 60; k++) begin
          i_fetch(rnd_addr(), l, r, e);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join

    // Store to 0x40 abandoned by reset while in WAIT.
    d_we = 1'b1; d_be = 4'hF; d_addr = 32'h40; d_wdata = 32'h5; d_req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    order_q.delete();
    fork
      begin
        @(negedge clk);
        chk("post-reset ready", {30'b0, d_ready, i_ready}, 32'h0);
        chk("post-reset d_rdata", d_rdata, 32'h0);
        chk("post-reset i_rdata", i_rdata, 32'h0);
      end
      begin : dtie
        int l; logic [31:0] r; logic e;
        d_xact(1'b0, 4'h0, 32'h40, 32'h0, l, r, e);
        chk("tie first latency", 32'(l), 32'd3);
        for (int k = 0; k < 3; k++)
          d_xact(1'b1, 4'hF, 32'($urandom_range(0, 255)) * 4, $urandom, l, r, e);
      end
      begin : itie
        int l; logic [31:0] r; logic e;
        for (int k = 0; k < 4; k++) i_fetch(32'($urandom_range(0, 255)) * 4, l, r, e);
      end
    join
    chk("tie count", 32'(order_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < order_q.size(); k++)
      chk($sformatf("tie order %0d", k), {31'b0, order_q[k]}, {31'b0, (k % 2) == 0});

    repeat (5) @(negedge clk);
    chk("queues drained", 32'(dq.size() + iq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Parametrised successor to the fixed split imem/dmem wiring at the SoC top level.
- Places one single-port unified word memory behind two request/ready ports: instruction fetch and data load/store.
- Adds configurable wait states, byte-enable writes, fair arbitration and error signalling for misaligned or out-of-range accesses.
- The mips core stalls on a pending port while that port's ready is low.

Parameters:
- ADDR_W, 32, byte-address width of both ports.
- DEPTH_WORDS, 256, memory depth in 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 1, extra cycles between grant and response; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction read request; held high until i_ready.
- i_addr  in  ADDR_W  instruction byte address.
- i_ready  out  1  one-cycle response strobe for the instruction port.
- i_rdata  out  32  instruction word; valid while i_ready is high.
- i_err  out  1  instruction access error; valid with i_ready.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables; bit n writes wdata[8n+7:8n].
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle response strobe for the data port.
- d_rdata  out  32  load data; valid while d_ready is high.
- d_err  out  1  data access error; valid with d_ready.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; wait counter = 0; last_grant = INSTR.
  - All ready, err and rdata outputs = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-transaction abandons it: no write occurs on the cycle reset is sampled, and no ready is issued.
- States:
  - IDLE: arbitrate on sampled requests.
    - Only one request high: grant it.
    - Both high: grant the port that is not last_grant (round-robin). Data wins the first tie after reset.
    - On grant: latch channel, address, we, be and wdata; update last_grant.
    - Go to WAIT if WAIT_CYCLES > 0, otherwise ACCESS.
  - WAIT: count WAIT_CYCLES cycles, then go to ACCESS.
  - ACCESS: perform the array read or write at word index addr[log2(DEPTH_WORDS)+1:2].
    - Assert the granted port's ready with rdata for exactly this cycle.
    - Return to IDLE.
- Latency:
  - Request sampled in IDLE at edge N gives ready high in the cycle after edge N+1+WAIT_CYCLES.
  - WAIT_CYCLES=0: ready 2 cycles after the request.
  - Back-to-back throughput: one access per 2+WAIT_CYCLES cycles.
- No new grant is made while state is not IDLE. The ungranted port's ready stays 0.
- Store:
  - Written bytes are those with d_be set; other bytes are unchanged.
  - d_rdata on a store response = 0.
  - d_be = 4'b0000 is a legal no-op and still gets a normal ready.
- Error: misaligned (addr[1:0] != 0) or addr >= 4*DEPTH_WORDS.
  - err=1 with ready; no memory write; rdata = 0. Timing is unchanged.
- Load after store to the same word returns the new data.
- Request inputs are ignored after the grant, since they are latched. A requester dropping req before ready is a protocol violation; the bench must flag it, the RTL is not required to handle it.
- ready and err are registered outputs (driven from state), with no combinational path from req.

Test Plan:
- Reset, WAIT_CYCLES=1: d_req=1, we=1, be=4'hF, addr=0x10, wdata=0xDEADBEEF, then load from 0x10 -> each d_ready arrives 3 cycles after its req; load returns d_rdata=0xDEADBEEF, d_err=0.
- Byte enables: store 0x11223344 to 0x20 with be=4'hF, then store 0xAABBCCDD with be=4'b0101, then load -> 0x11BB33DD.
- Tie arbitration: i_req and d_req high together from reset, both held -> data served first, then instruction. With both re-asserted continuously, grants alternate D, I, D, I.
- Errors: load from 0x13 -> d_err=1, d_rdata=0. Store to 4*DEPTH_WORDS (0x400 with default depth) -> d_err=1 and no memory word changes.
- Reset mid-op: assert reset in WAIT during a store of 0x5 to 0x40 -> no ready issued. A later load of 0x40 returns the pre-store value, and outputs are 0 in the cycle after reset.
- WAIT_CYCLES=0 and WAIT_CYCLES=15 builds: instruction fetch from 0x0 -> i_ready exactly 2 and 17 cycles after i_req respectively.
